paddle2quad: RTL and testbench

Converts an absolute 8-bit paddle/analog-stick position into a quadrature encoder pair so rotary-encoder-only game cores can be driven by a MiSTer paddle or analog stick. It sits directly upstream of the core's Enc_A/Enc_B inputs, in parallel with the digital joystick-to-quadrature path, and is selected by the top-level multiplexer. An internal position tracker walks toward the target one encoder step per tick, with a deadband to suppress analog jitter.

---
 rtl/paddle2quad_pkg.sv | 18 +
 rtl/paddle2quad_if.sv | 11 +
 rtl/paddle2quad_quad_tick.sv | 33 +++
 rtl/paddle2quad.sv | 121 ++++++++++++
 tb/tb_paddle2quad.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/paddle2quad_pkg.sv
// Shared types and helpers for the paddle-to-quadrature converter.
package paddle2quad_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    HOLD = 2'd1,
    MOVE = 2'd2
  } state_e;

  localparam int CLKDIV_DEFAULT = 5500;
  localparam int TC_W           = $clog2(CLKDIV_DEFAULT);

  // Quadrature phase to {A,B}: 0->00, 1->01, 2->11, 3->10.
  function automatic logic [1:0] gray2(input logic [1:0] ph);
    return {ph[1], ph[1] ^ ph[0]};
  endfunction

endpackage

// File: rtl/paddle2quad_if.sv
// Paddle source in, quadrature encoder pair and status out.
interface paddle2quad_if;
  logic       enable;
  logic [7:0] paddle;
  logic [1:0] steer;
  logic       moving;
  logic       dir;

  modport master (output enable, paddle, input steer, moving, dir);
  modport slave  (input enable, paddle, output steer, moving, dir);
endinterface

// File: rtl/paddle2quad_quad_tick.sv
// Step-rate divider: one-cycle tick every CLKDIV clocks, synchronous clear.
module quad_tick
  import paddle2quad_pkg::*;
#(
  parameter int CLKDIV = CLKDIV_DEFAULT,
  parameter int W      = TC_W
) (
  input  logic CLK,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [W-1:0] LAST = W'(CLKDIV - 1);

  logic [W-1:0] tc_q, tc_d;

  // Next count: wrap on tick, park at zero while cleared.
  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    tick = !clear && (tc_q == LAST);
    tc_d = tc_q + W'(1);
    if (clear || tick) tc_d = '0;
  end

  // Counter register.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) tc_q <= '0;
    else       tc_q <= tc_d;
  end

endmodule

// File: rtl/paddle2quad.sv
// Tracks an absolute paddle position and emits one quadrature step per tick toward it.
module paddle2quad
  import paddle2quad_pkg::*;
#(
  parameter int CLKDIV   = CLKDIV_DEFAULT,
  parameter int DEADBAND = 2
) (
  input logic          CLK,
  input logic          reset,
  paddle2quad_if.slave bus
);

  state_e      state_q, state_d;
  logic [7:0]  target_q, target_d;
  logic [7:0]  pos_q, pos_d;
  logic [1:0]  ph_q, ph_d;
  logic [1:0]  steer_q, steer_d;
  logic        dir_q, dir_d;
  logic        moving_q, moving_d;

  logic        tick;
  logic        tc_clear;
  logic signed [8:0] diff;
  logic [8:0]  mag;
  logic        step_en;
  logic        step_up;

  // Divider is held at zero in INIT so HOLD always starts a full period.
  assign tc_clear = (state_q == INIT) || !bus.enable;

  quad_tick #(
    .CLKDIV (CLKDIV),
    .W      ($clog2(CLKDIV))
  ) u_tick (
    .CLK   (CLK),
    .reset (reset),
    .clear (tc_clear),
    .tick  (tick)
  );

  // Signed distance to target; pos only moves toward target so it never wraps.
  always_comb begin
    diff    = $signed({1'b0, target_q}) - $signed({1'b0, pos_q});
    mag     = diff[8] ? 9'(-diff) : 9'(diff);
    step_up = !diff[8];
  end

  // FSM next state, step decision and position/phase update.
  always_comb begin
    state_d  = state_q;
    target_d = bus.paddle;
    pos_d    = pos_q;
    ph_d     = ph_q;
    dir_d    = dir_q;
    step_en  = 1'b0;

    case (state_q)
      INIT: begin
        if (bus.enable) begin
          pos_d   = target_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (tick && (mag > 9'(DEADBAND))) begin
          step_en = 1'b1;
          state_d = MOVE;
        end
      end
      MOVE: begin
        if (tick) begin
          if (diff != '0) step_en = 1'b1;
          else            state_d = HOLD;
        end
      end
      default: state_d = INIT;
    endcase

    // Deselecting the source freezes steer and drops back to INIT.
    if (!bus.enable) begin
      state_d = INIT;
      step_en = 1'b0;
    end

    if (step_en) begin
      pos_d = step_up ? pos_q + 8'd1 : pos_q - 8'd1;
      ph_d  = step_up ? ph_q + 2'd1  : ph_q - 2'd1;
      dir_d = step_up;
    end

    moving_d = (state_d == MOVE);
    // steer is registered from the next phase so a 01->10 phase change cannot glitch both wires.
    steer_d  = gray2(ph_d);
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q  <= INIT;
      target_q <= 8'h00;
      pos_q    <= 8'h00;
      ph_q     <= 2'd0;
      steer_q  <= 2'b00;
      dir_q    <= 1'b0;
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      pos_q    <= pos_d;
      ph_q     <= ph_d;
      steer_q  <= steer_d;
      dir_q    <= dir_d;
      moving_q <= moving_d;
    end
  end

  assign bus.steer  = steer_q;
  assign bus.moving = moving_q;
  assign bus.dir    = dir_q;

endmodule

// File: tb/tb_paddle2quad.sv
// Self-checking bench for paddle2quad with CLKDIV=4, DEADBAND=2.
module tb_paddle2quad;

  localparam int CLKDIV = 4;
  localparam int DB     = 2;

  logic CLK;
  logic reset;
  paddle2quad_if bus();

  paddle2quad #(.CLKDIV(CLKDIV), .DEADBAND(DB)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total;
  int bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] idx2code(input int idx);
    case (idx & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic int code2idx(input logic [1:0] c);
    case (c)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Reference model: walks an integer position toward the registered target,
  // one step every CLKDIV cycles, with a deadband only when starting from rest.
  int mtgt, mpos, mph, left;
  bit trk, run, mdir;

  always @(posedge CLK or posedge reset) begin : model
    int gap;
    if (reset) begin
      mtgt = 0; mpos = 0; mph = 0; left = 0;
      trk = 0; run = 0; mdir = 0;
    end else begin
      gap = mtgt - mpos;
      if (!bus.enable) begin
        trk = 0;
        run = 0;
      end else if (!trk) begin
        trk  = 1;
        mpos = mtgt;
        left = CLKDIV - 1;
      end else if (left != 0) begin
        left = left - 1;
      end else begin
        left = CLKDIV - 1;
        if (gap != 0 && (run || gap > DB || gap < -DB)) begin
          mpos = mpos + ((gap > 0) ? 1 : -1);
          mph  = (mph + ((gap > 0) ? 1 : 3)) % 4;
          mdir = (gap > 0);
          run  = 1;
        end else begin
          run = 0;
        end
      end
      mtgt = int'(bus.paddle);
    end
  end

  // Step monitor and per-cycle comparison against the model, sampled mid-cycle.
  logic [1:0] prev_steer;
  int inc_cnt, dec_cnt, obs_pos;

  always @(negedge CLK) begin : monitor
    int sd;
    if (reset) begin
      prev_steer = 2'b00;
    end else begin
      if (bus.steer != prev_steer) begin
        sd = (code2idx(bus.steer) - code2idx(prev_steer) + 4) % 4;
        check("one_bit_change", 32'(sd == 1 || sd == 3), 32'd1);
        if (sd == 1) begin inc_cnt++; obs_pos++; end
        else if (sd == 3) begin dec_cnt++; obs_pos--; end
        prev_steer = bus.steer;
      end
      check("model_steer",  32'(bus.steer),  32'(idx2code(mph)));
      check("model_moving", 32'(bus.moving), 32'(run));
      check("model_dir",    32'(bus.dir),    32'(mdir));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  typedef struct {
    logic [7:0] paddle;
    logic       en;
    int         cycles;
    logic [1:0] steer;
    logic       moving;
    logic       dir;
    int         steps;
    int         pos;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int s0, i0, d0, n;
    total = 0; bad = 0;
    inc_cnt = 0; dec_cnt = 0; obs_pos = 0;

    tbl[0] = '{8'h80, 1'b0,    3, 2'b00, 1'b0, 1'b0,   0, 'h00};
    tbl[1] = '{8'h80, 1'b1,  100, 2'b00, 1'b0, 1'b0,   0, 'h80};
    tbl[2] = '{8'h84, 1'b1,   40, 2'b00, 1'b0, 1'b1,   4, 'h84};
    tbl[3] = '{8'h85, 1'b1,   20, 2'b00, 1'b0, 1'b1,   0, 'h84};
    tbl[4] = '{8'h86, 1'b1,   20, 2'b00, 1'b0, 1'b1,   0, 'h84};
    tbl[5] = '{8'h85, 1'b1,   20, 2'b00, 1'b0, 1'b1,   0, 'h84};
    tbl[6] = '{8'h86, 1'b1,   20, 2'b00, 1'b0, 1'b1,   0, 'h84};
    tbl[7] = '{8'h87, 1'b1,   40, 2'b10, 1'b0, 1'b1,   3, 'h87};
    tbl[8] = '{8'h00, 1'b1,  600, 2'b00, 1'b0, 1'b0, 135, 'h00};
    tbl[9] = '{8'hFF, 1'b1, 1060, 2'b10, 1'b0, 1'b1, 255, 'hFF};

    reset = 1'b1;
    bus.enable = 1'b0;
    bus.paddle = 8'h00;
    cyc(3);
    check("reset_steer",  32'(bus.steer),  32'h0);
    check("reset_moving", 32'(bus.moving), 32'h0);
    check("reset_dir",    32'(bus.dir),    32'h0);
    reset = 1'b0;

    // Snap, forward tracking, deadband and both end stops.
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].en && !bus.enable) obs_pos = int'(bus.paddle);
      s0 = inc_cnt + dec_cnt;
      bus.paddle = tbl[i].paddle;
      bus.enable = tbl[i].en;
      cyc(tbl[i].cycles);
      check($sformatf("vec%0d_steer", i),  32'(bus.steer),  32'(tbl[i].steer));
      check($sformatf("vec%0d_moving", i), 32'(bus.moving), 32'(tbl[i].moving));
      check($sformatf("vec%0d_dir", i),    32'(bus.dir),    32'(tbl[i].dir));
      check($sformatf("vec%0d_steps", i),  32'(inc_cnt + dec_cnt - s0), 32'(tbl[i].steps));
      check($sformatf("vec%0d_pos", i),    32'(obs_pos),    32'(tbl[i].pos));
    end

    // Re-snap to 0x80 from 0xFF with zero steps (phase stays 3).
    bus.enable = 1'b0;
    bus.paddle = 8'h80;
    cyc(3);
    s0 = inc_cnt + dec_cnt;
    obs_pos = 'h80;
    bus.enable = 1'b1;
    cyc(20);
    check("resnap_steps", 32'(inc_cnt + dec_cnt - s0), 32'd0);

    // Reversal mid-move: 3 increments toward 0x90, then back to 0x80.
    i0 = inc_cnt; d0 = dec_cnt;
    bus.paddle = 8'h90;
    n = 0;
    while (n < 100 && (inc_cnt - i0) < 3) begin cyc(1); n++; end
    check("rev_incs_reached", 32'(inc_cnt - i0), 32'd3);
    bus.paddle = 8'h80;
    n = 0;
    while (n < 100 && (dec_cnt - d0) < 1) begin cyc(1); n++; end
    check("rev_first_dec_dir",   32'(bus.dir),   32'd0);
    check("rev_first_dec_steer", 32'(bus.steer), 32'(2'b01));
    cyc(40);
    check("rev_total_incs", 32'(inc_cnt - i0), 32'd3);
    check("rev_total_decs", 32'(dec_cnt - d0), 32'd3);
    check("rev_pos",        32'(obs_pos),      32'h80);
    check("rev_moving",     32'(bus.moving),   32'd0);
    check("rev_steer",      32'(bus.steer),    32'(2'b10));

    // Disable mid-move: 5 steps toward 0xC0 (phase 3 -> 0), then freeze.
    i0 = inc_cnt;
    bus.paddle = 8'hC0;
    n = 0;
    while (n < 100 && (inc_cnt - i0) < 5) begin cyc(1); n++; end
    check("dis_steps_before", 32'(inc_cnt - i0), 32'd5);
    bus.enable = 1'b0;
    s0 = inc_cnt + dec_cnt;
    cyc(30);
    check("dis_steer_frozen", 32'(bus.steer),  32'(2'b00));
    check("dis_moving",       32'(bus.moving), 32'd0);
    check("dis_no_steps",     32'(inc_cnt + dec_cnt - s0), 32'd0);
    obs_pos = 'hC0;
    bus.enable = 1'b1;
    cyc(40);
    check("reen_no_steps", 32'(inc_cnt + dec_cnt - s0), 32'd0);
    check("reen_moving",   32'(bus.moving), 32'd0);

    // Asynchronous reset mid-move: two decrements (phase 0 -> 2, steer 11) first.
    d0 = dec_cnt;
    bus.paddle = 8'h00;
    n = 0;
    while (n < 100 && (dec_cnt - d0) < 2) begin cyc(1); n++; end
    check("rst_steer_before", 32'(bus.steer), 32'(2'b11));
    check("rst_moving_before", 32'(bus.moving), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("rst_async_steer",  32'(bus.steer),  32'h0);
    check("rst_async_moving", 32'(bus.moving), 32'h0);
    check("rst_async_dir",    32'(bus.dir),    32'h0);
    cyc(2);
    reset = 1'b0;
    obs_pos = 0;
    s0 = inc_cnt + dec_cnt;
    cyc(50);
    check("rst_resume_steps",  32'(inc_cnt + dec_cnt - s0), 32'd0);
    check("rst_resume_steer",  32'(bus.steer),  32'h0);
    check("rst_resume_moving", 32'(bus.moving), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
